// File: rtl/playfield_state_pkg.sv
// Shared display/playfield types: board geometry, tile encoding, line-clear FSM states
// and the piece-coordinate types used by the lock and overlay ports.
package playfield_state_pkg;

  localparam int PLAYFIELD_DIM_Y = 20;
  localparam int PLAYFIELD_DIM_X = 10;
  localparam int NUM_PIECE_TILES = 4;

  typedef enum logic [2:0] {
    BLANK = 3'd0,
    I     = 3'd1,
    O     = 3'd2,
    T     = 3'd3,
    J     = 3'd4,
    L     = 3'd5,
    S     = 3'd6,
    Z     = 3'd7
  } tile_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } playfield_state_t;

  typedef logic [4:0] piece_row_t;
  typedef logic [3:0] piece_col_t;

  localparam piece_row_t LAST_ROW = piece_row_t'(PLAYFIELD_DIM_Y - 1);

  // Piece coordinates are wider than the board, so every use must be range-gated.
  function automatic logic tile_in_range(input piece_row_t row, input piece_col_t col);
    return (row < piece_row_t'(PLAYFIELD_DIM_Y)) && (col < piece_col_t'(PLAYFIELD_DIM_X));
  endfunction

endpackage

// File: rtl/playfield_state_overlay.sv
// Combinational overlay of a piece onto the board image; also intended for the ghost piece.
module playfield_overlay
  import playfield_state_pkg::*;
#(
  parameter int NUM_TILES = NUM_PIECE_TILES
) (
  input  tile_type_t board        [PLAYFIELD_DIM_Y][PLAYFIELD_DIM_X],
  input  logic       active_valid,
  input  tile_type_t active_type,
  input  piece_row_t active_row   [NUM_TILES],
  input  piece_col_t active_col   [NUM_TILES],
  output tile_type_t tile_type    [PLAYFIELD_DIM_Y][PLAYFIELD_DIM_X]
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < PLAYFIELD_DIM_Y; gi++) begin : g_row
      for (gj = 0; gj < PLAYFIELD_DIM_X; gj++) begin : g_col
        logic hit;

        // Out-of-range piece tiles can never equal an on-board coordinate.
        always_comb begin
          hit = 1'b0;
          for (int t = 0; t < NUM_TILES; t++) begin
            if (active_row[t] == piece_row_t'(gi) && active_col[t] == piece_col_t'(gj)) begin
              hit = 1'b1;
            end
          end
        end

        assign tile_type[gi][gj] = (active_valid && hit) ? active_type : board[gi][gj];
      end
    end
  endgenerate

endmodule

// File: rtl/playfield_state.sv
// Registered Tetris board with lock-piece handshake, bottom-up line-clear FSM
// and a combinational falling-piece overlay on the output image.
module playfield_state
  import playfield_state_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_board,
  input  logic       lock_valid,
  output logic       lock_ready,
  input  tile_type_t lock_type,
  input  piece_row_t lock_row      [NUM_PIECE_TILES],
  input  piece_col_t lock_col      [NUM_PIECE_TILES],
  input  logic       active_valid,
  input  tile_type_t active_type,
  input  piece_row_t active_row    [NUM_PIECE_TILES],
  input  piece_col_t active_col    [NUM_PIECE_TILES],
  output tile_type_t tile_type     [PLAYFIELD_DIM_Y][PLAYFIELD_DIM_X],
  output logic [2:0] lines_cleared,
  output logic       clear_done,
  output logic       lock_collision
);

  tile_type_t       board_q [PLAYFIELD_DIM_Y][PLAYFIELD_DIM_X];
  tile_type_t       board_d [PLAYFIELD_DIM_Y][PLAYFIELD_DIM_X];
  playfield_state_t state_q, state_d;
  piece_row_t       scan_row_q, scan_row_d;
  logic [2:0]       lines_q, lines_d;
  logic             clear_done_q, clear_done_d;
  logic             collision_q, collision_d;
  logic             row_full;

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < PLAYFIELD_DIM_X; c++) begin
      if (board_q[scan_row_q][c] == BLANK) begin
        row_full = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    scan_row_d   = scan_row_q;
    lines_d      = lines_q;
    board_d      = board_q;
    clear_done_d = 1'b0;
    collision_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_board) begin
          for (int r = 0; r < PLAYFIELD_DIM_Y; r++) begin
            for (int c = 0; c < PLAYFIELD_DIM_X; c++) begin
              board_d[r][c] = BLANK;
            end
          end
        end else if (lock_valid) begin
          // Collision looks at the pre-lock board, so duplicate tiles never self-collide.
          for (int t = 0; t < NUM_PIECE_TILES; t++) begin
            if (tile_in_range(lock_row[t], lock_col[t])) begin
              if (board_q[lock_row[t]][lock_col[t]] != BLANK) begin
                collision_d = 1'b1;
              end
              board_d[lock_row[t]][lock_col[t]] = lock_type;
            end
          end
          lines_d    = 3'd0;
          scan_row_d = LAST_ROW;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        if (row_full) begin
          state_d = SHIFT;
        end else if (scan_row_q == '0) begin
          state_d      = DONE;
          clear_done_d = 1'b1;
        end else begin
          scan_row_d = scan_row_q - piece_row_t'(1);
        end
      end

      SHIFT: begin
        for (int r = 1; r < PLAYFIELD_DIM_Y; r++) begin
          if (piece_row_t'(r) <= scan_row_q) begin
            board_d[r] = board_q[r-1];
          end
        end
        for (int c = 0; c < PLAYFIELD_DIM_X; c++) begin
          board_d[0][c] = BLANK;
        end
        if (lines_q != 3'd7) begin
          lines_d = lines_q + 3'd1;
        end
        // scan_row stays put: the row that just dropped in must be rescanned.
        state_d = SCAN;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      scan_row_q   <= LAST_ROW;
      lines_q      <= 3'd0;
      clear_done_q <= 1'b0;
      collision_q  <= 1'b0;
      for (int r = 0; r < PLAYFIELD_DIM_Y; r++) begin
        for (int c = 0; c < PLAYFIELD_DIM_X; c++) begin
          board_q[r][c] <= BLANK;
        end
      end
    end else begin
      state_q      <= state_d;
      scan_row_q   <= scan_row_d;
      lines_q      <= lines_d;
      clear_done_q <= clear_done_d;
      collision_q  <= collision_d;
      board_q      <= board_d;
    end
  end

  assign lock_ready     = (state_q == IDLE);
  assign lines_cleared  = lines_q;
  assign clear_done     = clear_done_q;
  assign lock_collision = collision_q;

  playfield_overlay #(
    .NUM_TILES (NUM_PIECE_TILES)
  ) u_overlay (
    .board        (board_q),
    .active_valid (active_valid),
    .active_type  (active_type),
    .active_row   (active_row),
    .active_col   (active_col),
    .tile_type    (tile_type)
  );

endmodule

// File: tb/tb_playfield_state.sv
// Self-checking bench for playfield_state: directed scenarios plus random locks
// and overlays checked against a row-list board model.
module tb_playfield_state;
  import playfield_state_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear_board = 1'b0;
  logic       lock_valid = 1'b0;
  logic       lock_ready;
  tile_type_t lock_type = BLANK;
  piece_row_t lock_row [NUM_PIECE_TILES];
  piece_col_t lock_col [NUM_PIECE_TILES];
  logic       active_valid = 1'b0;
  tile_type_t active_type = BLANK;
  piece_row_t active_row [NUM_PIECE_TILES];
  piece_col_t active_col [NUM_PIECE_TILES];
  tile_type_t tile_type_o [PLAYFIELD_DIM_Y][PLAYFIELD_DIM_X];
  logic [2:0] lines_cleared;
  logic       clear_done;
  logic       lock_collision;

  int checks = 0;
  int errors = 0;

  int mdl [20][10];
  int l_row [4];
  int l_col [4];
  int a_row [4];
  int a_col [4];
  int a_type = 0;
  bit a_valid = 1'b0;
  int diff_r, diff_c, diff_got, diff_exp;

  playfield_state dut (
    .clk            (clk),
    .reset          (reset),
    .clear_board    (clear_board),
    .lock_valid     (lock_valid),
    .lock_ready     (lock_ready),
    .lock_type      (lock_type),
    .lock_row       (lock_row),
    .lock_col       (lock_col),
    .active_valid   (active_valid),
    .active_type    (active_type),
    .active_row     (active_row),
    .active_col     (active_col),
    .tile_type      (tile_type_o),
    .lines_cleared  (lines_cleared),
    .clear_done     (clear_done),
    .lock_collision (lock_collision)
  );

  always #10 clk = ~clk;

  task automatic set_tiles(input int r0, c0, r1, c1, r2, c2, r3, c3);
    l_row[0] = r0; l_col[0] = c0;
    l_row[1] = r1; l_col[1] = c1;
    l_row[2] = r2; l_col[2] = c2;
    l_row[3] = r3; l_col[3] = c3;
  endtask

  task automatic model_blank();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        mdl[r][c] = 0;
  endtask

  // Game-rule model: write the piece, then drop every full row and refill from the top.
  task automatic model_lock(input int typ, output int coll, output int lines);
    int nb [20][10];
    int dst;
    bit full;
    coll = 0;
    for (int t = 0; t < 4; t++)
      if (l_row[t] < 20 && l_col[t] < 10 && mdl[l_row[t]][l_col[t]] != 0) coll = 1;
    for (int t = 0; t < 4; t++)
      if (l_row[t] < 20 && l_col[t] < 10) mdl[l_row[t]][l_col[t]] = typ;
    lines = 0;
    dst = 19;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        nb[r][c] = 0;
    for (int r = 19; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < 10; c++)
        if (mdl[r][c] == 0) full = 1'b0;
      if (full) lines++;
      else begin
        for (int c = 0; c < 10; c++) nb[dst][c] = mdl[r][c];
        dst--;
      end
    end
    mdl = nb;
  endtask

  function automatic int board_diff(input bit ov);
    int d = 0;
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 10; c++) begin
        int e;
        e = mdl[r][c];
        if (ov && a_valid)
          for (int t = 0; t < 4; t++)
            if (a_row[t] == r && a_col[t] == c) e = a_type;
        if (int'(tile_type_o[r][c]) != e) begin
          if (d == 0) begin
            diff_r = r; diff_c = c; diff_got = int'(tile_type_o[r][c]); diff_exp = e;
          end
          d++;
        end
      end
    end
    return d;
  endfunction

  task automatic drive_active();
    active_valid = a_valid;
    active_type  = tile_type_t'(a_type);
    for (int t = 0; t < 4; t++) begin
      active_row[t] = piece_row_t'(a_row[t]);
      active_col[t] = piece_col_t'(a_col[t]);
    end
  endtask

  task automatic do_lock(input int typ, input string name, input bit scan_poke);
    int exp_coll, exp_lines, exp_done, done_cyc, coll_first, coll_extra, d;
    bit poke_ready;
    model_lock(typ, exp_coll, exp_lines);
    exp_done = 21 + 2 * exp_lines;
    @(negedge clk);
    checks++;
    if (lock_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before got %0b want 1", name, lock_ready);
    end
    lock_valid = 1'b1;
    lock_type  = tile_type_t'(typ);
    for (int t = 0; t < 4; t++) begin
      lock_row[t] = piece_row_t'(l_row[t]);
      lock_col[t] = piece_col_t'(l_col[t]);
    end
    @(posedge clk);
    #1 lock_valid = 1'b0;
    done_cyc = 0; coll_first = 0; coll_extra = 0; poke_ready = 1'b0;
    for (int n = 1; n <= 60 && done_cyc == 0; n++) begin
      @(negedge clk);
      if (n == 1) coll_first = int'(lock_collision);
      else if (lock_collision === 1'b1) coll_extra++;
      if (clear_done === 1'b1) done_cyc = n;
      if (scan_poke && n == 3) begin
        poke_ready  = lock_ready;
        lock_valid  = 1'b1;
        clear_board = 1'b1;
        lock_type   = J;
        for (int t = 0; t < 4; t++) begin
          lock_row[t] = piece_row_t'(t);
          lock_col[t] = piece_col_t'(0);
        end
      end
      if (scan_poke && n == 4) begin
        lock_valid = 1'b0; clear_board = 1'b0;
      end
    end
    $display("lock %s type=%0d lines=%0d coll=%0d done_cycle=%0d", name, typ, lines_cleared,
             coll_first, done_cyc);
    checks++;
    if (done_cyc != exp_done) begin
      errors++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, exp_done);
    end
    checks++;
    if (coll_first != exp_coll || coll_extra != 0) begin
      errors++; $display("FAIL %s collision got %0d(+%0d) want %0d", name, coll_first, coll_extra, exp_coll);
    end
    if (scan_poke) begin
      checks++;
      if (poke_ready !== 1'b0) begin
        errors++; $display("FAIL %s ready_in_scan got %0b want 0", name, poke_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (lock_ready !== 1'b1 || clear_done !== 1'b0) begin
      errors++; $display("FAIL %s after_done ready=%0b done=%0b want 1 0", name, lock_ready, clear_done);
    end
    checks++;
    if (lines_cleared !== 3'(exp_lines)) begin
      errors++; $display("FAIL %s lines_cleared got %0d want %0d", name, lines_cleared, exp_lines);
    end
    d = board_diff(1'b0);
    checks++;
    if (d != 0) begin
      errors++;
      $display("FAIL %s board %0d cells differ, first (%0d,%0d) got %0d want %0d",
               name, d, diff_r, diff_c, diff_got, diff_exp);
    end
  endtask

  task automatic test_reset();
    int bad = 0, d;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_blank();
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (clear_done !== 1'b0 || lock_collision !== 1'b0 || lock_ready !== 1'b1) bad++;
    end
    $display("reset idle cycles=30 ready=%0b lines=%0d", lock_ready, lines_cleared);
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_idle_outputs got %0d bad cycles want 0", bad);
    end
    checks++;
    if (lines_cleared !== 3'd0) begin
      errors++; $display("FAIL reset_lines got %0d want 0", lines_cleared);
    end
    d = board_diff(1'b0);
    checks++;
    if (d != 0) begin
      errors++; $display("FAIL reset_board got %0d nonblank cells want 0", d);
    end
  endtask

  task automatic test_t_piece();
    set_tiles(19, 0, 19, 1, 19, 2, 18, 1);
    do_lock(3, "t_piece", 1'b0);
    checks++;
    if (tile_type_o[18][1] !== T) begin
      errors++; $display("FAIL t_piece_cell got %0d want %0d", tile_type_o[18][1], T);
    end
  endtask

  task automatic test_single_line();
    set_tiles(19, 3, 19, 4, 19, 5, 22, 0);
    do_lock(4, "prefill_row19", 1'b0);
    set_tiles(19, 6, 19, 7, 19, 8, 19, 9);
    do_lock(1, "single_line", 1'b0);
    checks++;
    if (tile_type_o[19][1] !== T || tile_type_o[18][1] !== BLANK) begin
      errors++;
      $display("FAIL single_line_stub got (19,1)=%0d (18,1)=%0d want %0d 0",
               tile_type_o[19][1], tile_type_o[18][1], T);
    end
  endtask

  task automatic test_four_lines();
    test_reset();
    for (int c = 0; c < 9; c++) begin
      set_tiles(16, c, 17, c, 18, c, 19, c);
      do_lock(6, "fill_col", 1'b0);
    end
    set_tiles(16, 9, 17, 9, 18, 9, 19, 9);
    do_lock(1, "four_lines", 1'b0);
  endtask

  task automatic test_collision();
    set_tiles(19, 0, 19, 1, 18, 1, 18, 2);
    do_lock(6, "s_base", 1'b0);
    set_tiles(19, 1, 17, 5, 17, 6, 17, 7);
    do_lock(7, "collide", 1'b1);
    checks++;
    if (tile_type_o[19][1] !== Z) begin
      errors++; $display("FAIL collide_cell got %0d want %0d", tile_type_o[19][1], Z);
    end
    set_tiles(10, 3, 10, 3, 10, 3, 10, 3);
    do_lock(5, "duplicate", 1'b0);
  endtask

  task automatic test_clear_board();
    int d;
    @(negedge clk);
    clear_board = 1'b1;
    lock_valid  = 1'b1;
    lock_type   = I;
    for (int t = 0; t < 4; t++) begin
      lock_row[t] = piece_row_t'(5);
      lock_col[t] = piece_col_t'(t);
    end
    @(posedge clk);
    #1 clear_board = 1'b0; lock_valid = 1'b0;
    model_blank();
    @(negedge clk);
    $display("clear_board ready=%0b coll=%0b", lock_ready, lock_collision);
    checks++;
    if (lock_ready !== 1'b1 || lock_collision !== 1'b0 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_board_status ready=%0b coll=%0b done=%0b want 1 0 0",
               lock_ready, lock_collision, clear_done);
    end
    d = board_diff(1'b0);
    checks++;
    if (d != 0) begin
      errors++; $display("FAIL clear_board_blank got %0d nonblank cells want 0", d);
    end
  endtask

  task automatic test_overlay();
    int d;
    test_reset();
    set_tiles(1, 4, 20, 0, 31, 2, 3, 12);
    do_lock(7, "z_seed", 1'b0);
    a_valid = 1'b1; a_type = 2;
    a_row[0] = 0; a_col[0] = 4; a_row[1] = 0; a_col[1] = 5;
    a_row[2] = 1; a_col[2] = 4; a_row[3] = 1; a_col[3] = 5;
    @(negedge clk);
    drive_active();
    #1;
    $display("overlay O valid=1 (1,4)=%0d", tile_type_o[1][4]);
    checks++;
    if (tile_type_o[0][4] !== O || tile_type_o[0][5] !== O || tile_type_o[1][4] !== O || tile_type_o[1][5] !== O) begin
      errors++;
      $display("FAIL overlay_cells got %0d %0d %0d %0d want %0d", tile_type_o[0][4], tile_type_o[0][5],
               tile_type_o[1][4], tile_type_o[1][5], O);
    end
    d = board_diff(1'b1);
    checks++;
    if (d != 0) begin
      errors++; $display("FAIL overlay_image %0d cells differ, first (%0d,%0d) got %0d want %0d",
                         d, diff_r, diff_c, diff_got, diff_exp);
    end
    a_valid = 1'b0;
    @(negedge clk);
    drive_active();
    #1;
    checks++;
    if (tile_type_o[1][4] !== Z || tile_type_o[0][4] !== BLANK) begin
      errors++; $display("FAIL overlay_drop got (1,4)=%0d (0,4)=%0d want %0d 0",
                         tile_type_o[1][4], tile_type_o[0][4], Z);
    end
  endtask

  task automatic test_reset_mid_scan();
    int pulses = 0, d;
    set_tiles(19, 0, 19, 1, 19, 2, 19, 3);
    @(negedge clk);
    lock_valid = 1'b1; lock_type = L;
    for (int t = 0; t < 4; t++) begin
      lock_row[t] = piece_row_t'(l_row[t]);
      lock_col[t] = piece_col_t'(l_col[t]);
    end
    @(posedge clk);
    #1 lock_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_blank();
    checks++;
    if (lock_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_scan_ready got %0b want 1", lock_ready);
    end
    d = board_diff(1'b0);
    checks++;
    if (d != 0) begin
      errors++; $display("FAIL reset_mid_scan_board got %0d nonblank cells want 0", d);
    end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (clear_done === 1'b1) pulses++;
    end
    $display("reset_mid_scan ready=%0b done_pulses=%0d", lock_ready, pulses);
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL reset_mid_scan_done got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_random();
    int br, bc, d;
    for (int k = 0; k < 40; k++) begin
      br = $urandom_range(19, 8);
      bc = $urandom_range(9, 0);
      for (int t = 0; t < 4; t++) begin
        if ($urandom_range(2, 0) == 0) begin
          l_row[t] = 19; l_col[t] = (bc + t) % 10;
        end else begin
          l_row[t] = br - $urandom_range(2, 0);
          l_col[t] = bc + $urandom_range(3, 0);
        end
        if ($urandom_range(9, 0) == 0) l_row[t] = l_row[t] + 12;
      end
      do_lock($urandom_range(7, 1), "random", (k % 7) == 3);
      a_valid = $urandom_range(1, 0);
      a_type  = $urandom_range(7, 1);
      for (int t = 0; t < 4; t++) begin
        a_row[t] = $urandom_range(21, 0);
        a_col[t] = $urandom_range(11, 0);
      end
      @(negedge clk);
      drive_active();
      #1;
      d = board_diff(1'b1);
      $display("overlay random valid=%0b type=%0d diffs=%0d", a_valid, a_type, d);
      checks++;
      if (d != 0) begin
        errors++; $display("FAIL random_overlay %0d cells differ, first (%0d,%0d) got %0d want %0d",
                           d, diff_r, diff_c, diff_got, diff_exp);
      end
      a_valid = 1'b0;
      @(negedge clk);
      drive_active();
    end
  endtask

  initial begin
    for (int t = 0; t < 4; t++) begin
      lock_row[t] = '0; lock_col[t] = '0;
      a_row[t] = 0; a_col[t] = 0;
    end
    drive_active();
    test_reset();
    test_t_piece();
    test_single_line();
    test_clear_board();
    test_four_lines();
    test_collision();
    test_overlay();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/playfield_state.md
Name: playfield_state

Overview:
- Holds the registered 20x10 Tetris board and drives the tile_type array consumed by the Playfield Pixel Driver.
- Accepts "lock piece" requests from game logic through a valid/ready handshake, writes the 4 tiles, then runs a line-clear FSM: scan rows bottom-up, shift down, count lines.
- Combinationally overlays the currently falling piece onto the output array so the PPD sees board plus active piece.

Parameters:
- NUM_PIECE_TILES, 4, tiles per piece in lock/overlay ports.
- Board dimensions come from DisplayPkg: PLAYFIELD_DIM_Y = 20, PLAYFIELD_DIM_X = 10. They are not parameters.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- clear_board  in  1  pulse; blanks the whole board (honoured only in IDLE)
- lock_valid  in  1  lock request valid
- lock_ready  out  1  high only in IDLE
- lock_type  in  tile_type_t  type written for all 4 tiles
- lock_row  in  4x5  row per tile (0 = top)
- lock_col  in  4x4  col per tile (0 = left)
- active_valid  in  1  falling piece present
- active_type  in  tile_type_t  falling piece type
- active_row  in  4x5  falling piece rows
- active_col  in  4x4  falling piece cols
- tile_type  out  [20][10] tile_type_t  board plus overlay, to the PPD
- lines_cleared  out  3  rows cleared by the last lock (0..4)
- clear_done  out  1  one-cycle pulse when line-clear finishes
- lock_collision  out  1  one-cycle pulse; a lock tile overwrote a non-BLANK cell

Behaviour:
- Reset (synchronous, active-high):
  - board all BLANK; state IDLE; scan_row = 19.
  - lines_cleared = 0, clear_done = 0, lock_collision = 0.
  - lock_ready = 1 (combinational from IDLE).
- FSM states: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - If clear_board: blank the board next edge; stay in IDLE; lock is not accepted that cycle.
  - Else if lock_valid && lock_ready: on that edge, write lock_type into each in-range (row, col).
  - Out-of-range tiles (row > 19 or col > 9) are dropped silently.
  - Duplicate coordinates write the same value, with no side effect.
  - lock_collision pulses next cycle if any in-range target cell was non-BLANK before the write; the write still happens.
  - On accept: lines_cleared <= 0, scan_row <= 19, go to SCAN.
- SCAN, one row per cycle:
  - If every cell of board[scan_row] is non-BLANK, go to SHIFT.
  - Else if scan_row == 0, go to DONE.
  - Else scan_row decrements.
- SHIFT, one cycle:
  - For r in 1..scan_row: board[r] <= board[r-1]. board[0] <= all BLANK.
  - lines_cleared increments, saturating at 7; legal play never exceeds 4.
  - Return to SCAN with scan_row unchanged, so the shifted-down row is rescanned.
- DONE: clear_done = 1 for exactly this cycle; next state IDLE.
- lines_cleared holds its value until the next lock is accepted.
- Latency, lock accepted at edge E0:
  - 0 lines: SCAN cycles 1..20, DONE in cycle 21, lock_ready high again in cycle 22.
  - Each cleared row adds 1 SHIFT cycle plus 1 rescan cycle.
- clear_board or lock_valid while not in IDLE: ignored, not queued. lock_ready = 0.
- Overlay (combinational):
  - tile_type[i][j] = active_type if active_valid and some active tile equals (i, j); otherwise board[i][j].
  - Out-of-range active tiles are ignored.
  - The overlay is unaffected by FSM state. During SHIFT the board changes and the overlay persists.
- Reset mid-operation: returns to IDLE with a blank board next edge; no clear_done pulse.

Decomposition:
- DisplayPkg already holds PLAYFIELD_DIM_Y, PLAYFIELD_DIM_X and tile_type_t (BLANK, I, O, T, J, L, S, Z).
- Add to DisplayPkg:
  - playfield_state_t enum (IDLE/SCAN/SHIFT/DONE).
  - piece_row_t (5b) and piece_col_t (4b) typedefs.
  - NUM_PIECE_TILES constant.
- One natural sub-module: playfield_overlay. It is purely combinational: board + active piece -> tile_type. It is reused later for a ghost-piece overlay.

Test Plan:
- Reset, then no stimulus -> all tile_type BLANK, lock_ready = 1, lines_cleared = 0, clear_done never pulses.
- Lock T at (19,0),(19,1),(19,2),(18,1) on an empty board -> those cells = T; clear_done in cycle 21 after accept; lines_cleared = 0; lock_ready back in cycle 22.
- Pre-fill row 19 cols 0..5 (setup locks); lock I at (19,6..9) -> row 19 cleared, the T stub at (18,1) moves to (19,1); lines_cleared = 1; clear_done in cycle 23.
- Rows 16..19 full except col 9; lock vertical I at col 9 rows 16..19 -> board all BLANK; lines_cleared = 4; clear_done in cycle 29.
- Lock onto an occupied cell -> lock_collision pulses once and the cell takes the new type. lock_valid during SCAN -> no write, lock_ready = 0.
- active_valid with O at (0,4),(0,5),(1,4),(1,5) over a board with (1,4) = Z -> output shows O at all four, board value Z unchanged once active_valid drops. Assert reset mid-SCAN -> IDLE, blank board, no clear_done.
